// File: rtl/serial_nibble_adder_ctrl_pkg.sv
// serial_nibble_adder_ctrl_pkg: shared FSM state encoding (IDLE/RUN/DONE, 2'd3 illegal), nibble width NIB_W and the SNA_W(n)=4*n wide-width macro
`ifndef SNA_W
`define SNA_W(n) (4*(n))
`endif
package serial_nibble_adder_ctrl_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_nibble_adder_ctrl_ripple_carry_4bit.sv
// ripple_carry_4bit: shared 4-bit ripple-carry adder; ports a, b, cin in -> sum, carry out
module ripple_carry_4bit
  import serial_nibble_adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             carry
);
  logic [NIB_W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign carry = c[NIB_W];
endmodule

// File: rtl/serial_nibble_adder_ctrl.sv
// serial_nibble_adder_ctrl: wide a+b+cin over one shared 4-bit adder, one nibble per clk; ports clk, rst, in_valid/in_ready/a/b/cin, out_valid/out_ready/sum/carry_out, busy, ovf when SERIAL_ADD_OVF_EN
module serial_nibble_adder_ctrl
  import serial_nibble_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [`SNA_W(NIBBLES)-1:0] a,
  input  logic [`SNA_W(NIBBLES)-1:0] b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [`SNA_W(NIBBLES)-1:0] sum,
  output logic                       carry_out,
  output logic                       busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                       ovf
`endif
);
  localparam int W = `SNA_W(NIBBLES);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0] a_sh, b_sh;
  logic [NIB_W-1:0] nib_sum;
  logic carry_r, nib_co, last, accept;
  ripple_carry_4bit u_add (
    .a(a_sh[NIB_W-1:0]),
    .b(b_sh[NIB_W-1:0]),
    .cin(carry_r),
    .sum(nib_sum),
    .carry(nib_co)
  );
  assign last      = cnt == CNT_W'(NIBBLES - 1);
  assign in_ready  = state == IDLE || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign busy      = state == RUN;
  // accept covers both IDLE and the back-to-back DONE case; illegal 2'd3 falls through to IDLE
  always_comb begin
    state_n = accept ? RUN :
              state == RUN ? (last ? DONE : RUN) :
              (state == DONE && !out_ready) ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_r   <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        carry_r <= cin;
        cnt     <= '0;
      end else if (state == RUN) begin
        sum[NIB_W*cnt +: NIB_W] <= nib_sum;
        carry_r <= nib_co;
        a_sh    <= a_sh >> NIB_W;
        b_sh    <= b_sh >> NIB_W;
        cnt     <= cnt + 1'b1;
        if (last) begin
          carry_out <= nib_co;
`ifdef SERIAL_ADD_OVF_EN
          // same-sign operands producing a differently-signed MSB == carry into MSB xor carry out
          ovf <= (a_sh[NIB_W-1] == b_sh[NIB_W-1]) && (nib_sum[NIB_W-1] != a_sh[NIB_W-1]);
`endif
        end
      end
    end
  end
endmodule
